// File: rtl/addsub_pkg.sv
// Shared definitions for serial_addsub_unit: B-operand select encodings and FSM state type.
package addsub_pkg;

  localparam logic [1:0] OpB    = 2'b00;
  localparam logic [1:0] OpNotB = 2'b01;
  localparam logic [1:0] OpZero = 2'b10;
  localparam logic [1:0] OpOnes = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/serial_addsub_unit_if.sv
// Request/response bus of serial_addsub_unit; ovf/zero exist only when ADDSUB_FLAGS_EN is defined.
interface serial_addsub_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             cout;
`ifdef ADDSUB_FLAGS_EN
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, op, cin, out_ready,
    input  in_ready, out_valid, d, cout, ovf, zero
  );
  modport slave (
    input  in_valid, a, b, op, cin, out_ready,
    output in_ready, out_valid, d, cout, ovf, zero
  );
`else
  modport master (
    output in_valid, a, b, op, cin, out_ready,
    input  in_ready, out_valid, d, cout
  );
  modport slave (
    input  in_valid, a, b, op, cin, out_ready,
    output in_ready, out_valid, d, cout
  );
`endif
endinterface

// File: rtl/chunk_adder.sv
// Combinational WIDTH-bit ripple-carry adder; also exposes the carry into the MSB for overflow.
module chunk_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin
    logic [WIDTH:0] c;
    c     = '0;
    sum   = '0;
    c[0]  = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout  = c[WIDTH];
    c_msb = c[WIDTH-1];
  end

endmodule

// File: rtl/serial_addsub_unit.sv
// Chunk-serial adder/subtractor: d = a + sel(op,b) + cin over WIDTH/CHUNK cycles.
// Optional signed-overflow and zero flags are built when ADDSUB_FLAGS_EN is defined.
module serial_addsub_unit
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic             clk,
  input logic             rst,
  serial_addsub_unit_if.slave bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHUNK - 1);

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              carry_q;
  logic [WIDTH-1:0]  d_q;
  logic              cout_q;
  logic              out_valid_q;

  logic [WIDTH-1:0]  bsel;
  logic [CHUNK-1:0]  chunk_a;
  logic [CHUNK-1:0]  chunk_b;
  logic [CHUNK-1:0]  chunk_sum;
  logic              chunk_cout;
  logic              chunk_c_msb;
  logic [WIDTH-1:0]  d_new;
  logic              last_chunk;

  always_comb begin
    bsel = bus.b;
    unique case (bus.op)
      OpB:    bsel = bus.b;
      OpNotB: bsel = ~bus.b;
      OpZero: bsel = '0;
      OpOnes: bsel = '1;
      default: bsel = bus.b;
    endcase
  end

  assign chunk_a    = a_q[idx_q*CHUNK +: CHUNK];
  assign chunk_b    = b_q[idx_q*CHUNK +: CHUNK];
  assign last_chunk = (idx_q == LastIdx);

  chunk_adder #(
    .WIDTH (CHUNK)
  ) u_chunk_adder (
    .a     (chunk_a),
    .b     (chunk_b),
    .cin   (carry_q),
    .sum   (chunk_sum),
    .cout  (chunk_cout),
    .c_msb (chunk_c_msb)
  );

  // Full result as it will look after this CALC edge; feeds the zero flag.
  always_comb begin
    d_new = d_q;
    d_new[idx_q*CHUNK +: CHUNK] = chunk_sum;
  end

`ifdef ADDSUB_FLAGS_EN
  logic ovf_q;
  logic zero_q;
`else
  logic unused_c_msb;
  assign unused_c_msb = chunk_c_msb;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      d_q         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ADDSUB_FLAGS_EN
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bsel;
            carry_q <= bus.cin;
            idx_q   <= '0;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          d_q     <= d_new;
          carry_q <= chunk_cout;
          idx_q   <= idx_q + 1'b1;
          if (last_chunk) begin
            cout_q      <= chunk_cout;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
`ifdef ADDSUB_FLAGS_EN
            ovf_q       <= chunk_c_msb ^ chunk_cout;
            zero_q      <= (d_new == '0);
`endif
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // in_ready drops combinationally with rst, not only after the next edge.
  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.d         = d_q;
  assign bus.cout      = cout_q;
`ifdef ADDSUB_FLAGS_EN
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
`endif

endmodule

// File: doc/serial_addsub_unit.md
SERIAL_ADDSUB_UNIT -- requirements
Module: serial_addsub_unit

Interface
REQ-001 Parameter WIDTH, 16, operand/result width in bits; SHALL be a multiple of CHUNK.
REQ-002 Parameter CHUNK, 4, bits processed per CALC cycle; NCHUNK = WIDTH/CHUNK.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  request valid.
REQ-006 in_ready  out  1  unit can accept a request.
REQ-007 a  in  WIDTH  operand A.
REQ-008 b  in  WIDTH  operand B.
REQ-009 op  in  2  B-select: 00 B, 01 ~B, 10 all-zeros, 11 all-ones.
REQ-010 cin  in  1  carry into bit 0.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 d  out  WIDTH  result = A + Bsel + cin, modulo 2^WIDTH.
REQ-014 cout  out  1  carry out of bit WIDTH-1.
REQ-015 ovf, zero  out  1 each  signed overflow / d==0; present only per REQ-032.

Function
REQ-016 FSM states SHALL be IDLE, CALC, DONE.
REQ-017 in_ready SHALL be 1 exactly when state==IDLE and rst==0.
REQ-018 IDLE: on edge with in_valid&&in_ready, latch a, Bsel(op,b), cin; clear chunk index; go CALC.
REQ-019 CALC: each edge adds chunk [idx*CHUNK +: CHUNK] of latched A and Bsel plus stored carry, writes that slice of d, stores chunk carry-out, increments idx.
REQ-020 CALC: on edge with idx==NCHUNK-1 go DONE; cout SHALL take final chunk carry-out.
REQ-021 Latency: out_valid SHALL rise exactly NCHUNK cycles after the accept edge (4 for defaults).
REQ-022 DONE: out_valid=1; d, cout, flags SHALL hold stable until out_valid&&out_ready edge, then go IDLE.
REQ-023 No accept in the DONE->IDLE handshake cycle; earliest next accept is the following edge.
REQ-024 Changes on a, b, op, cin, in_valid outside IDLE SHALL be ignored.
REQ-025 out_ready outside DONE SHALL be ignored.
REQ-026 d and cout SHALL retain the last result after handshake until overwritten by the next CALC.
REQ-027 NCHUNK==1 SHALL be legal: single CALC cycle.

Reset
REQ-028 rst high SHALL immediately force state IDLE, idx 0, stored carry 0, d 0, cout 0, out_valid 0, ovf 0, zero 0, in_ready 0.
REQ-029 rst during CALC or DONE SHALL discard the operation; no out_valid afterward.
REQ-030 First accept possible on first edge after rst deasserts.

Configuration
REQ-031 Macro ADDSUB_FLAGS_EN controls flag logic.
REQ-032 Defined: ovf = carry into bit WIDTH-1 XOR cout, zero = (d==0), both valid with out_valid; undefined: ovf/zero ports and logic absent, all else identical.

Structure
REQ-033 Package addsub_pkg SHALL hold op encoding constants and FSM state typedef.
REQ-034 Sub-module chunk_adder SHALL implement CHUNK-bit ripple add (a, b, cin -> sum, cout, carry into MSB); instantiated once, reused every CALC cycle.

Verification (WIDTH=16, CHUNK=4)
REQ-035 op=00 a=0x1234 b=0x1111 cin=0 -> d=0x2345 cout=0, out_valid 4 cycles after accept.
REQ-036 op=01 cin=1 a=0x0005 b=0x0007 -> d=0xFFFE cout=0 ovf=0; a=0x8000 b=0x0001 -> d=0x7FFF cout=1 ovf=1.
REQ-037 op=10 cin=1 a=0xFFFF -> d=0x0000 cout=1 zero=1; op=11 cin=0 a=0x0000 -> d=0xFFFF cout=0.
REQ-038 op=00 a=0x7FFF b=0x0001 cin=0 -> d=0x8000 ovf=1; then out_ready low 10 cycles -> d stable, in_ready=0, in_valid pulses ignored.
REQ-039 rst pulse at 2nd CALC cycle -> all outputs 0, no out_valid; next request a=0x0001 b=0x0001 op=00 -> d=0x0002.
REQ-040 Back-to-back requests with in_valid and out_ready held high -> one accept every 6 cycles, results in order.
